// File: rtl/snitch_ro_cache_ctrl_if.sv
// snitch_ro_cache_ctrl_if: config request, cache monitor and cache control signals of the RO cache sequencer
interface snitch_ro_cache_ctrl_if #(
  parameter int AxiAddrWidth = 48,
  parameter int NrAddrRules  = 1,
  parameter int CntW         = 3
);
  localparam int AW = NrAddrRules * AxiAddrWidth;
  logic          cfg_valid_i;
  logic          cfg_ready_o;
  logic          cfg_enable_i;
  logic          cfg_flush_i;
  logic [AW-1:0] cfg_start_addr_i;
  logic [AW-1:0] cfg_end_addr_i;
  logic          mon_ar_hs_i;
  logic          mon_r_last_hs_i;
  logic          enable_o;
  logic          flush_valid_o;
  logic          flush_ready_i;
  logic [AW-1:0] start_addr_o;
  logic [AW-1:0] end_addr_o;
  logic          busy_o;
  logic          done_o;
  logic [CntW-1:0] outstanding_o;
  modport master (
    output cfg_valid_i, cfg_enable_i, cfg_flush_i, cfg_start_addr_i, cfg_end_addr_i,
           mon_ar_hs_i, mon_r_last_hs_i, flush_ready_i,
    input  cfg_ready_o, enable_o, flush_valid_o, start_addr_o, end_addr_o, busy_o, done_o,
           outstanding_o
  );
  modport slave (
    input  cfg_valid_i, cfg_enable_i, cfg_flush_i, cfg_start_addr_i, cfg_end_addr_i,
           mon_ar_hs_i, mon_r_last_hs_i, flush_ready_i,
    output cfg_ready_o, enable_o, flush_valid_o, start_addr_o, end_addr_o, busy_o, done_o,
           outstanding_o
  );
endinterface

// File: rtl/snitch_ro_cache_ctrl.sv
// snitch_ro_cache_ctrl: drains in-flight cached reads, flushes, then atomically applies a new cache config
module snitch_ro_cache_ctrl #(
  parameter int   AxiAddrWidth = 48,
  parameter int   NrAddrRules  = 1,
  parameter int   MaxTrans     = 4,
  parameter logic EnableRst    = 1'b0
) (
  input logic clk_i,
  input logic rst_i,
  snitch_ro_cache_ctrl_if.slave bus
);
  localparam int AW   = NrAddrRules * AxiAddrWidth;
  localparam int CntW = $clog2(MaxTrans + 1);
  typedef enum logic [1:0] {IDLE, DRAIN, FLUSH, APPLY} state_e;
  state_e state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic enable_q, en_s, fl_s;
  logic [AW-1:0] start_q, end_q, start_s, end_s;
  logic inc, dec;
  assign inc = bus.mon_ar_hs_i && !bus.mon_r_last_hs_i;
  assign dec = bus.mon_r_last_hs_i && !bus.mon_ar_hs_i;
  // Saturate at both ends; the assertions below flag the monitor protocol violation.
  always_comb begin
    cnt_d = cnt_q;
    if (inc && cnt_q != CntW'(MaxTrans)) cnt_d = cnt_q + CntW'(1);
    else if (dec && cnt_q != '0) cnt_d = cnt_q - CntW'(1);
  end
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  state_d = bus.cfg_valid_i ? DRAIN : IDLE;
      DRAIN: state_d = (cnt_q == '0 && !bus.mon_ar_hs_i) ? (fl_s ? FLUSH : APPLY) : DRAIN;
      FLUSH: state_d = bus.flush_ready_i ? APPLY : FLUSH;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      enable_q <= EnableRst;
      start_q  <= '0;
      end_q    <= '0;
      en_s     <= 1'b0;
      fl_s     <= 1'b0;
      start_s  <= '0;
      end_s    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == IDLE && bus.cfg_valid_i) begin
        en_s    <= bus.cfg_enable_i;
        fl_s    <= bus.cfg_flush_i;
        start_s <= bus.cfg_start_addr_i;
        end_s   <= bus.cfg_end_addr_i;
      end
      if (state_q == APPLY) begin
        enable_q <= en_s;
        start_q  <= start_s;
        end_q    <= end_s;
      end
    end
  end
  assign bus.cfg_ready_o   = state_q == IDLE;
  assign bus.busy_o        = state_q != IDLE;
  assign bus.enable_o      = enable_q && state_q == IDLE;
  assign bus.flush_valid_o = state_q == FLUSH;
  assign bus.done_o        = state_q == APPLY;
  assign bus.start_addr_o  = start_q;
  assign bus.end_addr_o    = end_q;
  assign bus.outstanding_o = cnt_q;
  a_cnt_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
    !(inc && cnt_q == CntW'(MaxTrans)));
  a_cnt_underflow: assert property (@(posedge clk_i) disable iff (rst_i)
    !(dec && cnt_q == '0));
endmodule

// File: tb/tb_snitch_ro_cache_ctrl.sv
// tb_snitch_ro_cache_ctrl: per-cycle vector table plus a reset-during-flush sequence
module tb_snitch_ro_cache_ctrl;
  localparam logic [47:0] A = 48'h8000_0000, B = 48'h8001_0000;
  localparam logic [47:0] C = 48'h9000_0000, D = 48'h9000_1000;
  localparam logic [47:0] E = 48'hA000_0000, F = 48'hA000_8000;
  localparam logic [47:0] G = 48'hB000_0000, H = 48'hB001_0000;
  typedef struct {
    logic v, en, fl;
    logic [47:0] s, e;
    logic ar, rl, fr;
    logic [103:0] exp;
  } vec_t;
  logic clk = 1'b0;
  logic rst;
  int pass_cnt = 0, total_cnt = 0;
  vec_t vecs[$];
  snitch_ro_cache_ctrl_if #(.AxiAddrWidth(48), .NrAddrRules(1), .CntW(3)) bus ();
  snitch_ro_cache_ctrl #(.AxiAddrWidth(48), .NrAddrRules(1), .MaxTrans(4), .EnableRst(1'b1)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus(bus)
  );
  always #5 clk = ~clk;
  function automatic logic [103:0] pk(logic r, en, fv, b, d, logic [2:0] c, logic [47:0] so, eo);
    return {r, en, fv, b, d, c, so, eo};
  endfunction
  function automatic logic [103:0] got();
    return pk(bus.cfg_ready_o, bus.enable_o, bus.flush_valid_o, bus.busy_o, bus.done_o,
              bus.outstanding_o, bus.start_addr_o, bus.end_addr_o);
  endfunction
  task automatic chk(string name, logic [103:0] act, logic [103:0] req);
    total_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s: got %h expected %h (rdy,en,fv,busy,done,cnt,start,end)", name, act, req);
  endtask
  task automatic add(logic v, en, fl, logic [47:0] s, e, logic ar, rl, fr, logic [103:0] x);
    vecs.push_back('{v, en, fl, s, e, ar, rl, fr, x});
  endtask
  task automatic drive(logic v, en, fl, logic [47:0] s, e, logic ar, rl, fr);
    bus.cfg_valid_i      = v;
    bus.cfg_enable_i     = en;
    bus.cfg_flush_i      = fl;
    bus.cfg_start_addr_i = s;
    bus.cfg_end_addr_i   = e;
    bus.mon_ar_hs_i      = ar;
    bus.mon_r_last_hs_i  = rl;
    bus.flush_ready_i    = fr;
  endtask
  initial begin
    // reset state, then a minimal no-flush request
    add(0, 0, 0, 0, 0, 0, 0, 0, pk(1, 1, 0, 0, 0, 0, 0, 0));
    add(1, 1, 0, A, B, 0, 0, 0, pk(1, 1, 0, 0, 0, 0, 0, 0));
    add(0, 0, 0, 0, 0, 0, 0, 0, pk(0, 0, 0, 1, 0, 0, 0, 0));
    add(0, 0, 0, 0, 0, 0, 0, 0, pk(0, 0, 0, 1, 1, 0, 0, 0));
    // three ARs in IDLE (flush_ready ignored), then a flushing request
    add(0, 0, 0, 0, 0, 1, 0, 0, pk(1, 1, 0, 0, 0, 0, A, B));
    add(0, 0, 0, 0, 0, 1, 0, 1, pk(1, 1, 0, 0, 0, 1, A, B));
    add(0, 0, 0, 0, 0, 1, 0, 0, pk(1, 1, 0, 0, 0, 2, A, B));
    add(1, 1, 1, C, D, 0, 0, 0, pk(1, 1, 0, 0, 0, 3, A, B));
    add(0, 0, 0, 0, 0, 1, 1, 0, pk(0, 0, 0, 1, 0, 3, A, B));
    add(0, 0, 0, 0, 0, 0, 1, 1, pk(0, 0, 0, 1, 0, 3, A, B));
    add(0, 0, 0, 0, 0, 0, 1, 0, pk(0, 0, 0, 1, 0, 2, A, B));
    add(0, 0, 0, 0, 0, 0, 1, 0, pk(0, 0, 0, 1, 0, 1, A, B));
    add(0, 0, 0, 0, 0, 0, 0, 0, pk(0, 0, 0, 1, 0, 0, A, B));
    for (int i = 0; i < 5; i++) add(0, 0, 0, 0, 0, 0, 0, 0, pk(0, 0, 1, 1, 0, 0, A, B));
    add(0, 0, 0, 0, 0, 0, 0, 1, pk(0, 0, 1, 1, 0, 0, A, B));
    add(0, 0, 0, 0, 0, 0, 0, 0, pk(0, 0, 0, 1, 1, 0, A, B));
    // request held during DRAIN with a different payload is not taken
    add(1, 0, 0, E, F, 0, 0, 0, pk(1, 1, 0, 0, 0, 0, C, D));
    add(1, 1, 0, G, H, 1, 0, 0, pk(0, 0, 0, 1, 0, 0, C, D));
    add(1, 1, 0, G, H, 0, 1, 0, pk(0, 0, 0, 1, 0, 1, C, D));
    add(1, 1, 0, G, H, 0, 0, 0, pk(0, 0, 0, 1, 0, 0, C, D));
    add(1, 1, 0, G, H, 0, 0, 0, pk(0, 0, 0, 1, 1, 0, C, D));
    add(1, 1, 0, G, H, 0, 0, 0, pk(1, 0, 0, 0, 0, 0, E, F));
    add(0, 0, 0, 0, 0, 0, 0, 0, pk(0, 0, 0, 1, 0, 0, E, F));
    add(0, 0, 0, 0, 0, 0, 0, 0, pk(0, 0, 0, 1, 1, 0, E, F));
    add(0, 0, 0, 0, 0, 0, 0, 0, pk(1, 1, 0, 0, 0, 0, G, H));
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    foreach (vecs[i]) begin
      drive(vecs[i].v, vecs[i].en, vecs[i].fl, vecs[i].s, vecs[i].e, vecs[i].ar, vecs[i].rl, vecs[i].fr);
      chk($sformatf("vec%0d", i), got(), vecs[i].exp);
      @(negedge clk);
    end
    // reset while flushing with two counted ARs
    drive(1, 0, 1, C, D, 0, 0, 0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 8 && !bus.flush_valid_o; i++) @(negedge clk);
    chk("flush_reached", {103'd0, bus.flush_valid_o}, 104'd1);
    drive(0, 0, 0, 0, 0, 1, 0, 0);
    repeat (2) @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    chk("flush_cnt2", got(), pk(0, 0, 1, 1, 0, 2, G, H));
    rst = 1'b1;
    @(negedge clk);
    chk("rst_in_flush", got(), pk(1, 1, 0, 0, 0, 0, 0, 0));
    rst = 1'b0;
    @(negedge clk);
    chk("after_rst_no_done", got(), pk(1, 1, 0, 0, 0, 0, 0, 0));
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
